// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA 640x480@60 timing defaults and 3-bit colour codes.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Colour bits are {red, green, blue}.
    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

endpackage
`default_nettype wire

// File: rtl/vga_pixel_tick.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_tick
// Description : Divides clk into a one-clk pixel tick every CLK_DIV cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_tick #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [3:0] c_div_last = 4'(CLK_DIV - 1);

    logic [3:0] r_div;
    logic       w_tick;

    // With CLK_DIV=1 the divider never leaves 0, so the tick is permanently high.
    assign w_tick = (r_div == c_div_last);
    assign tick   = w_tick;

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_div <= 4'd0;
        end else begin
            r_div <= r_div + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_sync.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync
// Description : VGA timing counters plus aligned colour/sync output registers.
//               Optional macro VGA_FRAME_COUNT_EN adds an 8-bit frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int CLK_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] x,
    output logic [9:0] y,
    input  logic [2:0] rgb_in,
    output logic [2:0] rgb_out,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int          c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int          c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0]  c_h_last  = 10'(c_h_total - 1);
    localparam logic [9:0]  c_v_last  = 10'(c_v_total - 1);
    localparam logic [9:0]  c_h_vis   = 10'(H_VISIBLE);
    localparam logic [9:0]  c_v_vis   = 10'(V_VISIBLE);
    localparam logic [9:0]  c_hs_lo   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  c_hs_hi   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  c_vs_lo   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  c_vs_hi   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       w_tick;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_frame_wrap;
    logic       w_visible;
    logic       w_hsync_n;
    logic       w_vsync_n;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic [2:0] r_rgb;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_frame_start;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_h_wrap     = (r_h_cnt == c_h_last);
    assign w_v_wrap     = (r_v_cnt == c_v_last);
    assign w_frame_wrap = w_tick && w_h_wrap && w_v_wrap;
    assign w_visible    = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
    assign w_hsync_n    = !((r_h_cnt >= c_hs_lo) && (r_h_cnt <= c_hs_hi));
    assign w_vsync_n    = !((r_v_cnt >= c_vs_lo) && (r_v_cnt <= c_vs_hi));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (w_tick) begin
            r_h_cnt <= w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
            end
        end
    end

    // Output stage samples the same counter state as the lookup, so all four
    // outputs trail x/y by exactly one clk and stay mutually aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb         <= BLACK;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_visible ? rgb_in : BLACK;
            r_hsync       <= w_hsync_n;
            r_vsync       <= w_vsync_n;
            r_frame_start <= w_frame_wrap;
        end
    end

    assign x           = r_h_cnt;
    assign y           = r_v_cnt;
    assign rgb_out     = r_rgb;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] r_frame_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count <= 8'd0;
        end else if (w_frame_wrap) begin
            r_frame_count <= r_frame_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync
// Description : Scoreboard bench for vga_sync; instance a at CLK_DIV=1, b at 4,
//               both with short frames. Honours VGA_FRAME_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync;
    import vga_pkg::*;

    localparam int HT    = 800;
    localparam int HV    = 640;
    localparam int HS_LO = 656;
    localparam int HS_HI = 751;

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic [2:0] rgb_in_a, rgb_in_b, rgb_out_a, rgb_out_b;
    logic       hsync_a, vsync_a, fs_a, hsync_b, vsync_b, fs_b;
    logic [7:0] fc_a, fc_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cyc [2];
    int   fcm   [2];
    exp_t sb_q_a [$];
    exp_t sb_q_b [$];
    int   fs_cnt_a = 0, fs_cnt_b = 0;
    logic fs_b_prev = 1'b0;
    int   hs_low_run = 0, vs_low_run = 0;

    always #5 clk = ~clk;

    function automatic int f_div(input int d);  return (d == 0) ? 1  : 4; endfunction
    function automatic int f_vvis(input int d); return (d == 0) ? 20 : 2; endfunction
    function automatic int f_vfr(input int d);  return (d == 0) ? 2  : 1; endfunction
    function automatic int f_vsy(input int d);  return (d == 0) ? 2  : 1; endfunction
    function automatic int f_vbk(input int d);  return (d == 0) ? 3  : 1; endfunction
    function automatic int f_vt(input int d);
        return f_vvis(d) + f_vfr(d) + f_vsy(d) + f_vbk(d);
    endfunction

    // Stand-in for the cell/colour lookup: solid white on line 0, pattern elsewhere.
    function automatic logic [2:0] f_lookup(input logic [9:0] px, input logic [9:0] py);
        return (py == 10'd0) ? WHITE : (px[2:0] ^ py[2:0]);
    endfunction

    assign rgb_in_a = f_lookup(x_a, y_a);
    assign rgb_in_b = f_lookup(x_b, y_b);

    vga_sync #(
        .V_VISIBLE (20), .V_FRONT (2), .V_SYNC (2), .V_BACK (3), .CLK_DIV (1)
    ) u_dut_a (
        .clk (clk), .rst (rst_a), .x (x_a), .y (y_a), .rgb_in (rgb_in_a),
        .rgb_out (rgb_out_a), .hsync (hsync_a), .vsync (vsync_a), .frame_start (fs_a)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count (fc_a)
`endif
    );

    vga_sync #(
        .V_VISIBLE (2), .V_FRONT (1), .V_SYNC (1), .V_BACK (1), .CLK_DIV (4)
    ) u_dut_b (
        .clk (clk), .rst (rst_b), .x (x_b), .y (y_b), .rgb_in (rgb_in_b),
        .rgb_out (rgb_out_b), .hsync (hsync_b), .vsync (vsync_b), .frame_start (fs_b)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count (fc_b)
`endif
    );

`ifndef VGA_FRAME_COUNT_EN
    assign fc_a = 8'd0;
    assign fc_b = 8'd0;
`endif

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, act, expv);
        end
    endtask

    // One scoreboard step per instance: compare last cycle's prediction, then
    // check x/y against the cycle-count model and push the next prediction.
    task automatic sb_step(input int d, input logic rst_now,
                           input logic [9:0] ox, input logic [9:0] oy,
                           input logic [2:0] orgb, input logic ohs, input logic ovs,
                           input logic ofs, input logic [7:0] ofc);
        exp_t  e;
        int    p, mx, my, vlo, vhi;
        logic  have;
        string pfx;
        pfx  = (d == 0) ? "a." : "b.";
        have = 1'b0;
        if (d == 0 && sb_q_a.size() > 0) begin
            e = sb_q_a.pop_front(); have = 1'b1;
        end else if (d == 1 && sb_q_b.size() > 0) begin
            e = sb_q_b.pop_front(); have = 1'b1;
        end
        if (have) begin
            check_val({pfx, "rgb_out"}, 32'(orgb), 32'(e.rgb));
            check_val({pfx, "hsync"}, 32'(ohs), 32'(e.hs));
            check_val({pfx, "vsync"}, 32'(ovs), 32'(e.vs));
            check_val({pfx, "frame_start"}, 32'(ofs), 32'(e.fs));
`ifdef VGA_FRAME_COUNT_EN
            check_val({pfx, "frame_count"}, 32'(ofc), 32'(e.fc));
`endif
        end
        if (rst_now) begin
            e        = '{rgb: 3'b000, hs: 1'b1, vs: 1'b1, fs: 1'b0, fc: 8'd0};
            n_cyc[d] = 0;
            fcm[d]   = 0;
        end else begin
            p   = n_cyc[d] / f_div(d);
            mx  = p % HT;
            my  = (p / HT) % f_vt(d);
            vlo = f_vvis(d) + f_vfr(d);
            vhi = vlo + f_vsy(d) - 1;
            check_val({pfx, "x"}, 32'(ox), mx);
            check_val({pfx, "y"}, 32'(oy), my);
            e.rgb = (mx < HV && my < f_vvis(d)) ? f_lookup(10'(mx), 10'(my)) : 3'b000;
            e.hs  = !(mx >= HS_LO && mx <= HS_HI);
            e.vs  = !(my >= vlo && my <= vhi);
            e.fs  = ((n_cyc[d] % f_div(d)) == f_div(d) - 1) && mx == HT - 1 && my == f_vt(d) - 1;
            if (e.fs) fcm[d] = (fcm[d] + 1) % 256;
            e.fc  = 8'(fcm[d]);
            n_cyc[d]++;
        end
        if (d == 0) sb_q_a.push_back(e);
        else        sb_q_b.push_back(e);
    endtask

    always @(negedge clk) begin
        sb_step(0, rst_a, x_a, y_a, rgb_out_a, hsync_a, vsync_a, fs_a, fc_a);
        sb_step(1, rst_b, x_b, y_b, rgb_out_b, hsync_b, vsync_b, fs_b, fc_b);
        if (fs_a) fs_cnt_a++;
        if (fs_b) begin
            fs_cnt_b++;
            check_val("b.frame_start_width", 32'(fs_b_prev), 32'd0);
        end
        fs_b_prev = fs_b;
        if (!hsync_a) hs_low_run++;
        else begin
            if (hs_low_run > 0) check_val("a.hsync_low_len", hs_low_run, 96);
            hs_low_run = 0;
        end
        if (!vsync_a) vs_low_run++;
        else begin
            if (vs_low_run > 0) check_val("a.vsync_low_len", vs_low_run, 2 * HT);
            vs_low_run = 0;
        end
    end

    initial begin
        logic hit;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Run into the second frame of instance a, then reset it mid-frame.
        hit = 1'b0;
        for (int i = 0; i < 60000; i++) begin
            @(posedge clk);
            #1;
            if (fs_cnt_a >= 1 && x_a == 10'd300 && y_a == 10'd10) begin
                hit = 1'b1;
                break;
            end
        end
        check_val("a.mid_reset_point_reached", 32'(hit), 32'd1);
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;

        // One full short frame (800*27 clks) plus margin after the reset.
        repeat (HT * 27 + 5) @(posedge clk);
        #1;
        check_val("a.frame_start_pulses", fs_cnt_a, 2);
        check_val("b.frame_start_pulses", fs_cnt_b, n_cyc[1] / (4 * HT * 5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync.md
# vga_sync

VGA 640x480@60 timing generator and output stage for the Game of Life display path. It produces the pixel coordinates that drive the combinational cell/colour lookup stage and takes back that stage's 3-bit colour. It registers colour, syncs and blanking together so they leave the chip aligned. It sits between the pixel clock source and the VGA connector.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 1, clk cycles per pixel (1..16); 1 means clk is the pixel clock

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- x  out  10  current horizontal count, 0..H_TOTAL-1; feeds the colour lookup stage
- y  out  10  current vertical count, 0..V_TOTAL-1; feeds the colour lookup stage
- rgb_in  in  3  colour from the lookup stage; combinationally valid for the current x/y
- rgb_out  out  3  registered, blanked colour to the connector
- hsync  out  1  registered horizontal sync, active low
- vsync  out  1  registered vertical sync, active low
- frame_start  out  1  one-clk pulse when counters wrap to (0,0)

## Operation
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
- Divider `div` counts 0..CLK_DIV-1. `tick` = (div == CLK_DIV-1). With CLK_DIV=1, tick is always 1.
- On tick:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only on an h wrap; at V_TOTAL-1 it wraps to 0.
- x = h_cnt and y = v_cnt, driven directly from the counter registers (not blanked).
- visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- Every clk, the output registers load:
  - rgb_out <= visible ? rgb_in : 3'b000
  - hsync <= !(h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]), i.e. low for 656..751
  - vsync <= !(v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]), i.e. low for 490..491
  - frame_start <= tick && h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1
- Reset values: div=0, h_cnt=0, v_cnt=0 (so x=0, y=0), rgb_out=0, hsync=1, vsync=1, frame_start=0.
- The reset state does not produce a frame_start pulse.
- Reset asserted mid-frame: all of the above reset values hold on the next clk edge, regardless of tick or div.
- Counting arithmetic is 10-bit unsigned; compares use the parameter sums.

## Timing
- x/y change only on clk edges where tick=1.
- Lookup path x/y -> rgb_in is combinational and must settle within one clk.
- rgb_out, hsync, vsync and frame_start lag their x/y by exactly 1 clk. All four are mutually aligned.
- frame_start is high in the same clk in which x/y first read (0,0) of a new frame. Width is 1 clk independent of CLK_DIV.
- With CLK_DIV>1, outputs stay stable across the CLK_DIV clks of a pixel, except the 1-clk frame_start.

## Configuration
- Macro: VGA_FRAME_COUNT_EN.
- Defined: adds output port `frame_count` out 8.
  - Reset value 0.
  - Increments by 1 in the clk where frame_start is loaded high, so it updates in the same cycle frame_start rises.
  - Wraps 255->0.
  - Used as the generation-step timebase.
- Undefined: no port and no counter logic; all other behaviour is identical.

## Structure
- Shared package `vga_pkg`:
  - default timing constants (H_*/V_* values, H_TOTAL, V_TOTAL)
  - 3-bit colour constants BLACK..WHITE (000..111)
- One sub-module, `vga_pixel_tick`: the CLK_DIV divider, with inputs clk and rst and output tick.
- The h/v counters and the output register stage live in vga_sync.

## Test plan
- Reset and line wrap (CLK_DIV=1): release rst at cycle 0.
  - x=0, y=0 initially.
  - After 799 clks: x=799, y=0.
  - After 800 clks: x=0, y=1.
- hsync window (CLK_DIV=1): x reaches 656 -> hsync low on the following clk. It stays low for 96 clks. It returns high the clk after x=752.
- vsync and frame wrap (CLK_DIV=1):
  - vsync is low while y is 490..491 (plus 1-clk lag).
  - frame_start pulses exactly once, at clk 420000 after reset, when x/y=(0,0).
  - With VGA_FRAME_COUNT_EN defined, frame_count becomes 1 in that same clk.
- Blanking (CLK_DIV=1): hold rgb_in=3'b111.
  - rgb_out=111 the clk after x=639.
  - rgb_out=000 the clk after x=640.
  - rgb_out=000 throughout y>=480.
- Divider (CLK_DIV=4): x increments every 4 clks. A line takes 3200 clks. frame_start remains a 1-clk pulse.
- Mid-frame reset: pulse rst for 1 clk at x=300, y=200.
  - Next clk: x=0, y=0, rgb_out=0, hsync=1, vsync=1, frame_start=0.
  - Counting then resumes normally.
